// File: rtl/bs_iter.sv
// Iterative barrel shifter: one log2 stage per cycle, MSB stage first.
// Handshaked command in, held result out; shift/rotate in either direction.
module bs_iter #(
  parameter int unsigned W       = 32,
  parameter int unsigned SHIFT_W = $clog2(W)
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               in_vld_i,
  output logic               in_rdy_o,
  input  logic [W-1:0]       in_x_i,
  input  logic [SHIFT_W-1:0] in_shift_i,
  input  logic               in_is_arith_i,
  input  logic               in_is_rotate_i,
  input  logic               in_is_right_i,
  output logic               out_vld_o,
  input  logic               out_rdy_i,
  output logic [W-1:0]       out_y_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [SHIFT_W-1:0] cnt_q;
  logic [SHIFT_W-1:0] shamt_q;
  logic [W-1:0]       word_q, word_d;
  logic               arith_q, rot_q, right_q, sign_q;
  logic               accept;

  assign accept = in_vld_i && (state_q == StIdle);

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_vld_i) state_d = StShift;
      StShift: if (cnt_q == '0) state_d = StDone;
      StDone:  if (out_rdy_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_rdy_o  = 1'b0;
    out_vld_o = 1'b0;
    busy_o    = 1'b1;
    unique case (state_q)
      StIdle: begin
        in_rdy_o = 1'b1;
        busy_o   = 1'b0;
      end
      StShift: ;
      StDone:  out_vld_o = 1'b1;
      default: begin
        in_rdy_o = 1'b1;
        busy_o   = 1'b0;
      end
    endcase
  end

  // One stage: move by 2^cnt_q if that shift-amount bit is set.
  always_comb begin
    int unsigned    amt;
    logic [W-1:0]   shr, shl, fill, stepped;
    amt     = 32'd1 << cnt_q;
    shr     = word_q >> amt;
    shl     = word_q << amt;
    // Vacated MSBs after a right move, filled with the captured sign bit
    fill    = ~({W{1'b1}} >> amt) & {W{sign_q}};
    stepped = shl;
    if (rot_q) begin
      stepped = right_q ? (shr | (word_q << (W - amt))) : (shl | (word_q >> (W - amt)));
    end else if (right_q) begin
      stepped = arith_q ? (shr | fill) : shr;
    end
    word_d = shamt_q[cnt_q] ? stepped : word_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q   <= '0;
      shamt_q <= '0;
      word_q  <= '0;
      arith_q <= 1'b0;
      rot_q   <= 1'b0;
      right_q <= 1'b0;
      sign_q  <= 1'b0;
    end else if (accept) begin
      cnt_q   <= SHIFT_W'(SHIFT_W - 1);
      shamt_q <= in_shift_i;
      word_q  <= in_x_i;
      arith_q <= in_is_arith_i;
      rot_q   <= in_is_rotate_i;
      right_q <= in_is_right_i;
      sign_q  <= in_x_i[W-1];
    end else if (state_q == StShift) begin
      word_q <= word_d;
      cnt_q  <= cnt_q - SHIFT_W'(1);
    end
  end

  assign out_y_o = word_q;

endmodule

// File: doc/bs_iter.md
BS_ITER -- requirements
Module: bs_iter

Interface
REQ-001 SHALL have parameter W, default 32, data width; legal values are powers of two, 2 <= W <= 64.
REQ-002 SHALL have parameter SHIFT_W, default $clog2(W), shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port arst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_vld_i  input  1  command valid.
REQ-006 SHALL have port in_rdy_o  output  1  command ready.
REQ-007 SHALL have port in_x_i  input  W  operand.
REQ-008 SHALL have port in_shift_i  input  SHIFT_W  shift amount, 0..W-1.
REQ-009 SHALL have port in_is_arith_i  input  1  arithmetic (sign-fill) select.
REQ-010 SHALL have port in_is_rotate_i  input  1  rotate select.
REQ-011 SHALL have port in_is_right_i  input  1  direction select, 1 = right.
REQ-012 SHALL have port out_vld_o  output  1  result valid.
REQ-013 SHALL have port out_rdy_i  input  1  result ready.
REQ-014 SHALL have port out_y_o  output  W  result.
REQ-015 SHALL have port busy_o  output  1  high when state is not IDLE.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-017 SHALL drive in_rdy_o high only in IDLE; a command is accepted on an edge where in_vld_i & in_rdy_o are both high.
REQ-018 On accept, SHALL register operand, shift amount and the three control bits, load stage counter = SHIFT_W-1, and enter SHIFT.
REQ-019 In SHIFT, each cycle SHALL apply stage k = counter: if shift bit k is set, move the working word by 2^k positions in the latched direction; otherwise hold it.
REQ-020 SHALL decrement the counter each SHIFT cycle and enter DONE after the stage-0 cycle; SHIFT therefore lasts exactly SHIFT_W cycles, independent of the shift amount.
REQ-021 Latency: for an accept on edge T, SHALL assert out_vld_o from cycle T+SHIFT_W+1 onward.
REQ-022 SHALL hold out_vld_o high and out_y_o stable in DONE until out_rdy_i is high, then return to IDLE on that edge.
REQ-023 SHALL NOT accept a command while in DONE; minimum issue-to-issue spacing is SHIFT_W+2 cycles.
REQ-024 Left shift SHALL zero-fill the vacated LSBs; in_is_arith_i SHALL be ignored for left shifts.
REQ-025 Logical right shift SHALL zero-fill the vacated MSBs.
REQ-026 Arithmetic right shift SHALL fill the vacated MSBs with bit W-1 of the original operand, captured at accept.
REQ-027 Rotate SHALL wrap bits in the latched direction; in_is_arith_i SHALL be ignored when rotating.
REQ-028 Shift amount 0 SHALL yield out_y_o = operand for all modes.
REQ-029 out_y_o SHALL be the final working word in DONE; in other states its value is don't-care for checking, but it SHALL be 0 out of reset.
REQ-030 Input changes while the block is not in IDLE SHALL have no effect on the in-flight result.
REQ-031 SHALL assert busy_o in SHIFT and DONE, and deassert it in IDLE.

Reset
REQ-032 While arst_n is low, SHALL force state IDLE, counter 0, out_vld_o=0, out_y_o=0, busy_o=0, in_rdy_o=1.
REQ-033 Asserting reset mid-SHIFT or in DONE SHALL discard the in-flight command; no out_vld_o pulse SHALL follow deassertion.
REQ-034 The first command after reset deassertion SHALL be acceptable on the first rising edge with arst_n high.

Verification (W=8, SHIFT_W=3)
REQ-035 Accept x=8'hB4, shift=2, left, logical -> out_vld_o in cycle T+4, y=8'hD0.
REQ-036 x=8'h90, shift=3, right, arith -> y=8'hF2; same with arith=0 -> y=8'h12.
REQ-037 x=8'h81, shift=1, right, rotate -> y=8'hC0; x=8'h81, shift=4, left, rotate, arith=1 -> y=8'h18.
REQ-038 Hold out_rdy_i=0 for 5 cycles after out_vld_o rises; toggle in_vld_i and in_x_i -> y held, in_rdy_o=0; release -> IDLE next cycle, then next command accepted.
REQ-039 Pulse arst_n low during the 2nd SHIFT cycle -> out_vld_o stays 0, in_rdy_o=1; new command x=8'h01, shift=0 -> y=8'h01.
